// File: rtl/qm_pipeline_pkg.sv
// Shared constants for the qm pipeline-register bank.
package qm_pipeline_pkg;

    localparam int unsigned STAGES_MAX = 8;
    localparam int unsigned WIDTH_DEF  = 64;
    localparam int unsigned CNT_W_DEF  = 32;

endpackage

// File: rtl/qm_pipeline_if.sv
// Producer-side handshake into register 0 of the pipeline bank.
interface qm_pipeline_if #(
    parameter int unsigned WIDTH = 64
);
    logic             i_Valid;
    logic [WIDTH-1:0] i_Data;
    logic             o_Ready;

    modport master (
        output i_Valid,
        output i_Data,
        input  o_Ready
    );

    modport slave (
        input  i_Valid,
        input  i_Data,
        output o_Ready
    );
endinterface

// File: rtl/qm_pipeline_stage.sv
// One valid/data pipeline register: hold, load a bubble, or load the source.
module qm_pipeline_stage #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             bubble,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (!hold) begin
            if (bubble) begin
                valid <= 1'b0;
                data  <= '0;
            end else begin
                valid <= src_valid;
                data  <= src_data;
            end
        end
    end

endmodule

// File: rtl/qm_pipeline.sv
// N-stage pipeline-register bank with stall backpressure, branch flush and
// retire/bubble/flush performance counters.
module qm_pipeline
    import qm_pipeline_pkg::*;
#(
    parameter int unsigned STAGES = 4,
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    qm_pipeline_if.slave            bus,
    input  logic [STAGES-1:0]       i_Stall,
    input  logic [STAGES-1:0]       i_Flush,
    output logic [STAGES-1:0]       o_Valid,
    output logic [STAGES*WIDTH-1:0] o_Data,
    output logic [CNT_W-1:0]        o_RetireCount,
    output logic [CNT_W-1:0]        o_BubbleCount,
    output logic [CNT_W-1:0]        o_FlushCount
);

    if (STAGES < 2 || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("qm_pipeline: STAGES out of range");
    end

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] stall_e;
    logic [STAGES-1:0] flush_e;
    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] hold;
    logic              any_flush;

    logic [CNT_W-1:0] retire_q;
    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W-1:0] flush_q;

    // kill[k] is set when any older register flushes; hold ripples down from the oldest stage.
    always_comb begin
        stall_e   = valid_q & i_Stall;
        flush_e   = valid_q & i_Flush;
        any_flush = |flush_e;
        kill      = '0;
        hold      = '0;
        hold[STAGES-1] = stall_e[STAGES-1];
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            kill[k] = kill[k+1] | flush_e[k+1];
            hold[k] = valid_q[k] && (stall_e[k] || hold[k+1]) && !kill[k];
        end
    end

    assign bus.o_Ready = !hold[0] && !any_flush;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic             src_bubble;

        if (k == 0) begin : g_head
            assign src_valid  = bus.i_Valid;
            assign src_data   = bus.i_Data;
            assign src_bubble = any_flush;
        end else begin : g_body
            assign src_valid  = valid_q[k-1];
            assign src_data   = data_q[k-1];
            assign src_bubble = kill[k-1] | hold[k-1];
        end

        qm_pipeline_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .hold      (hold[k]),
            .bubble    (src_bubble),
            .src_valid (src_valid),
            .src_data  (src_data),
            .valid     (valid_q[k]),
            .data      (data_q[k])
        );

        assign o_Data[k*WIDTH +: WIDTH] = data_q[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_q <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (valid_q[STAGES-1] && !hold[STAGES-1]) begin
                retire_q <= retire_q + CNT_W'(1);
            end
            if (!valid_q[STAGES-1]) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
            if (any_flush) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign o_Valid       = valid_q;
    assign o_RetireCount = retire_q;
    assign o_BubbleCount = bubble_q;
    assign o_FlushCount  = flush_q;

endmodule

// File: tb/tb_qm_pipeline.sv
// Directed bench for qm_pipeline: STAGES=4, WIDTH=8, CNT_W=4.
module tb_qm_pipeline;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  i_Stall = 4'h0;
    logic [3:0]  i_Flush = 4'h0;
    logic [3:0]  o_Valid;
    logic [31:0] o_Data;
    logic [3:0]  o_RetireCount;
    logic [3:0]  o_BubbleCount;
    logic [3:0]  o_FlushCount;

    int tests = 0;
    int fails = 0;

    qm_pipeline_if #(.WIDTH(8)) bus ();

    qm_pipeline #(
        .STAGES (4),
        .WIDTH  (8),
        .CNT_W  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .i_Stall       (i_Stall),
        .i_Flush       (i_Flush),
        .o_Valid       (o_Valid),
        .o_Data        (o_Data),
        .o_RetireCount (o_RetireCount),
        .o_BubbleCount (o_BubbleCount),
        .o_FlushCount  (o_FlushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [7:0]  id;
        logic [3:0]  st;
        logic [3:0]  fl;
        logic        rdy;
        logic [3:0]  val;
        logic [31:0] dat;
        logic [3:0]  ret;
        logic [3:0]  bub;
        logic [3:0]  flc;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] id, input logic [3:0] st,
                         input logic [3:0] fl);
        bus.i_Valid = iv;
        bus.i_Data  = id;
        i_Stall     = st;
        i_Flush     = fl;
    endtask

    initial begin
        // Streaming, stall on reg 1, flush on reg 2, flush+stall, empty-stage stall, bubble wrap.
        vecs[0]  = '{1'b1, 8'h01, 4'h0, 4'h0, 1'b1, 4'b0001, 32'h00000001, 4'd0, 4'd1,  4'd0};
        vecs[1]  = '{1'b1, 8'h02, 4'h0, 4'h0, 1'b1, 4'b0011, 32'h00000102, 4'd0, 4'd2,  4'd0};
        vecs[2]  = '{1'b1, 8'h03, 4'h0, 4'h0, 1'b1, 4'b0111, 32'h00010203, 4'd0, 4'd3,  4'd0};
        vecs[3]  = '{1'b1, 8'h04, 4'h0, 4'h0, 1'b1, 4'b1111, 32'h01020304, 4'd0, 4'd4,  4'd0};
        vecs[4]  = '{1'b1, 8'h05, 4'h0, 4'h0, 1'b1, 4'b1111, 32'h02030405, 4'd1, 4'd4,  4'd0};
        vecs[5]  = '{1'b1, 8'h06, 4'h0, 4'h0, 1'b1, 4'b1111, 32'h03040506, 4'd2, 4'd4,  4'd0};
        vecs[6]  = '{1'b1, 8'h07, 4'h2, 4'h0, 1'b0, 4'b1011, 32'h04000506, 4'd3, 4'd4,  4'd0};
        vecs[7]  = '{1'b1, 8'h07, 4'h2, 4'h0, 1'b0, 4'b0011, 32'h00000506, 4'd4, 4'd4,  4'd0};
        vecs[8]  = '{1'b1, 8'h07, 4'h2, 4'h0, 1'b0, 4'b0011, 32'h00000506, 4'd4, 4'd5,  4'd0};
        vecs[9]  = '{1'b1, 8'h07, 4'h0, 4'h0, 1'b1, 4'b0111, 32'h00050607, 4'd4, 4'd6,  4'd0};
        vecs[10] = '{1'b1, 8'h08, 4'h0, 4'h0, 1'b1, 4'b1111, 32'h05060708, 4'd4, 4'd7,  4'd0};
        vecs[11] = '{1'b1, 8'h09, 4'h0, 4'h4, 1'b0, 4'b1000, 32'h06000000, 4'd5, 4'd7,  4'd1};
        vecs[12] = '{1'b1, 8'h09, 4'h0, 4'h0, 1'b1, 4'b0001, 32'h00000009, 4'd6, 4'd7,  4'd1};
        vecs[13] = '{1'b1, 8'h0A, 4'h0, 4'h0, 1'b1, 4'b0011, 32'h0000090A, 4'd6, 4'd8,  4'd1};
        vecs[14] = '{1'b1, 8'h0B, 4'h0, 4'h0, 1'b1, 4'b0111, 32'h00090A0B, 4'd6, 4'd9,  4'd1};
        vecs[15] = '{1'b1, 8'h0C, 4'h2, 4'h4, 1'b0, 4'b1000, 32'h09000000, 4'd6, 4'd10, 4'd2};
        vecs[16] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 4'b0000, 32'h00000000, 4'd7, 4'd10, 4'd2};
        vecs[17] = '{1'b1, 8'h11, 4'h0, 4'h0, 1'b1, 4'b0001, 32'h00000011, 4'd7, 4'd11, 4'd2};
        vecs[18] = '{1'b0, 8'h00, 4'h4, 4'h0, 1'b1, 4'b0010, 32'h00001100, 4'd7, 4'd12, 4'd2};
        vecs[19] = '{1'b1, 8'h12, 4'h4, 4'h0, 1'b1, 4'b0101, 32'h00110012, 4'd7, 4'd13, 4'd2};
        vecs[20] = '{1'b0, 8'h00, 4'h4, 4'h0, 1'b1, 4'b0110, 32'h00111200, 4'd7, 4'd14, 4'd2};
        vecs[21] = '{1'b0, 8'h00, 4'h4, 4'h0, 1'b1, 4'b0110, 32'h00111200, 4'd7, 4'd15, 4'd2};
        vecs[22] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 4'b1100, 32'h11120000, 4'd7, 4'd0,  4'd2};
        vecs[23] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 4'b1000, 32'h12000000, 4'd8, 4'd0,  4'd2};
        vecs[24] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 4'b0000, 32'h00000000, 4'd9, 4'd0,  4'd2};

        drive(1'b0, 8'h00, 4'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset valid",  32'(o_Valid), 32'h0);
        check("reset data",   o_Data, 32'h0);
        check("reset retire", 32'(o_RetireCount), 32'h0);
        check("reset bubble", 32'(o_BubbleCount), 32'h0);
        check("reset flush",  32'(o_FlushCount), 32'h0);
        check("reset ready",  32'(bus.o_Ready), 32'h1);

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].st, vecs[i].fl);
            #1;
            check($sformatf("v%0d ready", i), 32'(bus.o_Ready), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d valid", i),  32'(o_Valid), 32'(vecs[i].val));
            check($sformatf("v%0d data", i),   o_Data, vecs[i].dat);
            check($sformatf("v%0d retire", i), 32'(o_RetireCount), 32'(vecs[i].ret));
            check($sformatf("v%0d bubble", i), 32'(o_BubbleCount), 32'(vecs[i].bub));
            check($sformatf("v%0d flush", i),  32'(o_FlushCount), 32'(vecs[i].flc));
        end

        // Reset mid-stream discards in-flight work and clears counters in one edge.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 8'(i + 32), 4'h0, 4'h0);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        drive(1'b1, 8'h55, 4'h0, 4'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset valid",  32'(o_Valid), 32'h0);
        check("midreset data",   o_Data, 32'h0);
        check("midreset retire", 32'(o_RetireCount), 32'h0);
        check("midreset bubble", 32'(o_BubbleCount), 32'h0);
        check("midreset flush",  32'(o_FlushCount), 32'h0);
        #1;
        check("midreset ready",  32'(bus.o_Ready), 32'h1);

        // Retire counter wraps to zero after 16 retires (20 streaming cycles).
        for (int n = 1; n <= 20; n++) begin
            drive(1'b1, 8'(n), 4'h0, 4'h0);
            #1;
            if (bus.o_Ready !== 1'b1) begin
                check($sformatf("wrap ready %0d", n), 32'(bus.o_Ready), 32'h1);
            end
            @(posedge clk);
            #1;
            if (n == 19) check("wrap retire 15", 32'(o_RetireCount), 32'd15);
        end
        check("wrap retire 0", 32'(o_RetireCount), 32'd0);
        check("wrap data",     o_Data, 32'h11121314);
        check("wrap valid",    32'(o_Valid), 32'hF);
        check("wrap bubble",   32'(o_BubbleCount), 32'd4);

        drive(1'b0, 8'h00, 4'h0, 4'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
